// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM and ALU decoder of the multicycle MIPS core.
// Moore outputs come from state; only PCEn also depends on zero. Write enables are forced low while rst=1.
module mips_multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCEn,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);
  typedef enum logic [STATE_W-1:0] {
    FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6,
    ALUWB = 7, BEQ = 8, BNE = 9, ADDIEX = 10, ADDIWB = 11, JUMP = 12
  } state_t;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_J = 6'b000010;
  state_t state_q, state_d;
  logic ir_w, pc_w, mem_w, reg_w, ill, branch, branch_ne, funct_ok;
  logic [2:0] funct_ctl;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  assign funct_ok  = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  assign funct_ctl = funct == 6'b100010 ? 3'b110 :
                     funct == 6'b100100 ? 3'b000 :
                     funct == 6'b100101 ? 3'b001 :
                     funct == 6'b101010 ? 3'b111 : 3'b010;
  always_comb begin
    state_d    = FETCH;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ill        = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    IorD       = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b010;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    case (state_q)
      FETCH: begin
        ir_w = 1'b1; pc_w = 1'b1; ALUSrcB = 2'b01; state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BEQ;
          OP_BNE:       state_d = BNE;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      ill = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; state_d = opcode == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD:  begin IorD = 1'b1; state_d = MEMWB; end
      MEMWB:  begin reg_w = 1'b1; MemtoReg = 1'b1; end
      MEMWR:  begin IorD = 1'b1; mem_w = 1'b1; end
      EXEC: begin
        ALUSrcA = 1'b1; ALUControl = funct_ctl; ill = ~funct_ok; state_d = ALUWB;
      end
      ALUWB:  begin reg_w = 1'b1; RegDst = 1'b1; end
      BEQ, BNE: begin
        ALUSrcA = 1'b1; ALUControl = 3'b110; branch = 1'b1; PCSrc = 2'b01;
        branch_ne = state_q == BNE;
      end
      ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; state_d = ADDIWB; end
      ADDIWB: reg_w = 1'b1;
      JUMP:   begin pc_w = 1'b1; PCSrc = 2'b10; end
      default: ;
    endcase
  end
  assign IRWrite    = ir_w & ~rst;
  assign MemWrite   = mem_w & ~rst;
  assign RegWrite   = reg_w & ~rst;
  assign illegal_op = ill & ~rst;
  assign PCEn       = (pc_w | (branch & (zero ^ branch_ne))) & ~rst;
  assign state_o    = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed instruction sequences checked cycle by cycle against a per-state output table.
module tb_mips_multicycle_control;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0;
  logic [5:0] opcode = 6'b000000, funct = 6'b100000;
  logic IorD, MemWrite, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg, RegWrite, illegal_op;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] state_o;
  int checks = 0, errors = 0;
  logic [19:0] sb[$];

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Expected {IorD,MemWrite,IRWrite,PCEn,PCSrc,ALUSrcA,ALUSrcB,ALUControl,RegDst,MemtoReg,RegWrite,illegal_op}
  function automatic logic [15:0] model(input logic [3:0] s);
    logic iord = 0, mw = 0, irw = 0, pcen = 0, srca = 0, rdst = 0, m2r = 0, rw = 0, il = 0;
    logic [1:0] pcsrc = 0, srcb = 0;
    logic [2:0] ctl = 3'b010;
    case (s)
      0: begin irw = 1; pcen = 1; srcb = 2'b01; end
      1: begin
        srcb = 2'b11;
        il = !(opcode inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010});
      end
      2: begin srca = 1; srcb = 2'b10; end
      3: iord = 1;
      4: begin rw = 1; m2r = 1; end
      5: begin iord = 1; mw = 1; end
      6: begin
        srca = 1;
        case (funct)
          6'b100000: ctl = 3'b010;
          6'b100010: ctl = 3'b110;
          6'b100100: ctl = 3'b000;
          6'b100101: ctl = 3'b001;
          6'b101010: ctl = 3'b111;
          default:   il = 1;
        endcase
      end
      7: begin rw = 1; rdst = 1; end
      8: begin srca = 1; ctl = 3'b110; pcsrc = 2'b01; pcen = zero; end
      9: begin srca = 1; ctl = 3'b110; pcsrc = 2'b01; pcen = !zero; end
      10: begin srca = 1; srcb = 2'b10; end
      11: rw = 1;
      12: begin pcen = 1; pcsrc = 2'b10; end
      default: ;
    endcase
    if (rst) begin irw = 0; pcen = 0; mw = 0; rw = 0; il = 0; end
    return {iord, mw, irw, pcen, pcsrc, srca, srcb, ctl, rdst, m2r, rw, il};
  endfunction

  task automatic check(input logic [3:0] s, input string tag, input bit at_neg = 1'b1);
    logic [19:0] e, obs;
    sb.push_back({s, model(s)});
    if (at_neg) @(negedge clk); else #1;
    e = sb.pop_front();
    obs = {state_o, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUControl,
           RegDst, MemtoReg, RegWrite, illegal_op};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [23:0] seq, input int n, input string name);
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < n; i++) begin
      check(seq[4*i +: 4], $sformatf("%s_c%0d", name, i));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    check(4'd0, "reset0");
    @(posedge clk); #1;
    check(4'd0, "reset1");
    @(posedge clk); #1;
    rst = 1'b0;
    instr(6'b100011, 6'b100000, 1'b0, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 5, "lw");
    instr(6'b101011, 6'b100000, 1'b0, {4'd5, 4'd2, 4'd1, 4'd0}, 4, "sw");
    instr(6'b000000, 6'b101010, 1'b0, {4'd7, 4'd6, 4'd1, 4'd0}, 4, "slt");
    instr(6'b000000, 6'b100010, 1'b1, {4'd7, 4'd6, 4'd1, 4'd0}, 4, "sub");
    instr(6'b000000, 6'b100100, 1'b0, {4'd7, 4'd6, 4'd1, 4'd0}, 4, "and");
    instr(6'b000000, 6'b100101, 1'b0, {4'd7, 4'd6, 4'd1, 4'd0}, 4, "or");
    instr(6'b000000, 6'b111111, 1'b0, {4'd7, 4'd6, 4'd1, 4'd0}, 4, "badfunct");
    instr(6'b000100, 6'b100000, 1'b1, {4'd8, 4'd1, 4'd0}, 3, "beq_taken");
    instr(6'b000100, 6'b100000, 1'b0, {4'd8, 4'd1, 4'd0}, 3, "beq_not");
    instr(6'b000101, 6'b100000, 1'b1, {4'd9, 4'd1, 4'd0}, 3, "bne_not");
    instr(6'b000101, 6'b100000, 1'b0, {4'd9, 4'd1, 4'd0}, 3, "bne_taken");
    instr(6'b001000, 6'b100000, 1'b0, {4'd11, 4'd10, 4'd1, 4'd0}, 4, "addi");
    instr(6'b000010, 6'b100000, 1'b0, {4'd12, 4'd1, 4'd0}, 3, "j");
    instr(6'b111111, 6'b100000, 1'b0, {4'd1, 4'd0}, 2, "badop");
    instr(6'b101011, 6'b100000, 1'b0, {4'd2, 4'd1, 4'd0}, 3, "sw_abort");
    check(4'd5, "sw_abort_memwr");
    #2 rst = 1'b1;
    check(4'd0, "abort_in_reset", 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check(4'd0, "abort_fetch");
    @(posedge clk); #1;
    check(4'd1, "abort_decode");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
